multi_edge_detect: RTL and testbench

MULTI_EDGE_DETECT -- requirements
Module: multi_edge_detect

---
 rtl/multi_edge_detect.sv | 107 ++++++++++
 tb/tb_multi_edge_detect.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector: per-channel synchroniser, persistence filter,
// registered rise/fall/tick pulses and a sticky pending flag.
module multi_edge_detect #(
   parameter int N_CH        = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CNT    = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_CH-1:0]     level,
   input  logic [2*N_CH-1:0]   mode,
   input  logic [N_CH-1:0]     evt_clr,
   output logic [N_CH-1:0]     tick,
   output logic [N_CH-1:0]     rise,
   output logic [N_CH-1:0]     fall,
   output logic [N_CH-1:0]     level_q,
   output logic [N_CH-1:0]     evt_pend
);

   localparam int             CW       = (FILT_CNT < 1) ? 1 : $clog2(FILT_CNT + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(FILT_CNT - 1);

   // Filter state per channel is simply the accepted level
   localparam logic ST_LOW  = 1'b0;
   localparam logic ST_HIGH = 1'b1;

   logic [N_CH-1:0] r_sync [SYNC_STAGES];
   logic [CW-1:0]   r_cnt  [N_CH];
   logic [N_CH-1:0] r_levelQ;
   logic [N_CH-1:0] r_rise;
   logic [N_CH-1:0] r_fall;
   logic [N_CH-1:0] r_tick;
   logic [N_CH-1:0] r_evtPend;

   logic [N_CH-1:0] w_syncOut;
   logic [N_CH-1:0] w_differ;
   logic [N_CH-1:0] w_accept;
   logic [N_CH-1:0] w_tickEn;

   assign w_syncOut = r_sync[SYNC_STAGES-1];
   assign w_differ  = w_syncOut ^ r_levelQ;

   always_comb begin
      w_accept = '0;
      w_tickEn = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_accept[i] = w_differ[i] && (r_cnt[i] == CNT_LAST);
         // mode bit 0 enables rising edges, bit 1 enables falling edges
         w_tickEn[i] = (w_syncOut[i] == ST_HIGH) ? mode[2*i] : mode[2*i+1];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            r_sync[s] <= '0;
         end
      end else begin
         r_sync[0] <= level;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            r_sync[s] <= r_sync[s-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_levelQ <= '0;
         for (int i = 0; i < N_CH; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (!w_differ[i]) begin
               r_cnt[i] <= '0;
            end else if (w_accept[i]) begin
               r_levelQ[i] <= w_syncOut[i] ? ST_HIGH : ST_LOW;
               r_cnt[i]    <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CW'(1);
            end
         end
      end
   end

   // Pending flag sees tick one cycle late; a tick beats a simultaneous clear
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rise    <= '0;
         r_fall    <= '0;
         r_tick    <= '0;
         r_evtPend <= '0;
      end else begin
         r_rise    <= w_accept & w_syncOut;
         r_fall    <= w_accept & ~w_syncOut;
         r_tick    <= w_accept & w_tickEn;
         r_evtPend <= r_tick | (r_evtPend & ~evt_clr);
      end
   end

   assign tick     = r_tick;
   assign rise     = r_rise;
   assign fall     = r_fall;
   assign level_q  = r_levelQ;
   assign evt_pend = r_evtPend;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Self-checking bench for multi_edge_detect: directed vector table, corner-case
// sequences and randomized traffic checked against a run-length reference model.
module tb_multi_edge_detect;

   localparam int N_CH = 4;
   localparam int SYNC = 2;
   localparam int FILT = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [N_CH-1:0]   level = '0;
   logic [2*N_CH-1:0] mode = 8'h55;
   logic [N_CH-1:0]   evt_clr = '0;
   logic [N_CH-1:0]   tick, rise, fall, level_q, evt_pend;

   int checks = 0;
   int failures = 0;
   logic modelOn = 1'b0;

   always #5 clk = ~clk;

   multi_edge_detect #(.N_CH(N_CH), .SYNC_STAGES(SYNC), .FILT_CNT(FILT)) dut (
      .clk(clk), .reset(reset), .level(level), .mode(mode), .evt_clr(evt_clr),
      .tick(tick), .rise(rise), .fall(fall), .level_q(level_q), .evt_pend(evt_pend)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [N_CH-1:0] lvl, input logic [2*N_CH-1:0] md,
                                input logic [N_CH-1:0] clr);
      level = lvl;
      mode = md;
      evt_clr = clr;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Reference model: the level seen SYNC edges ago must differ from the accepted
   // level for FILT consecutive edges before it is accepted
   logic [N_CH-1:0] mHist[$];
   int              mRun[N_CH];
   logic [N_CH-1:0] mLq = '0, mRise = '0, mFall = '0, mTick = '0, mPend = '0;
   logic [N_CH-1:0] mSeen;

   always @(posedge clk) begin
      if (!reset) begin
         mHist = {};
         for (int s = 0; s < SYNC; s++) mHist.push_back('0);
         for (int i = 0; i < N_CH; i++) mRun[i] = 0;
         mLq = '0; mRise = '0; mFall = '0; mTick = '0; mPend = '0;
      end else begin
         mPend = mTick | (mPend & ~evt_clr);
         mSeen = mHist[SYNC-1];
         mRise = '0; mFall = '0; mTick = '0;
         for (int i = 0; i < N_CH; i++) begin
            if (mSeen[i] == mLq[i]) begin
               mRun[i] = 0;
            end else begin
               mRun[i]++;
               if (mRun[i] == FILT) begin
                  mLq[i] = mSeen[i];
                  mRun[i] = 0;
                  if (mSeen[i]) mRise[i] = 1'b1;
                  else mFall[i] = 1'b1;
                  mTick[i] = mode[2*i + (mSeen[i] ? 0 : 1)];
               end
            end
         end
         mHist.push_front(level);
         void'(mHist.pop_back());
      end
   end

   always @(negedge clk) begin
      if (modelOn) begin
         checkOutput("model rise", rise, mRise);
         checkOutput("model fall", fall, mFall);
         checkOutput("model tick", tick, mTick);
         checkOutput("model level_q", level_q, mLq);
         checkOutput("model evt_pend", evt_pend, mPend);
      end
   end

   typedef struct {
      logic [N_CH-1:0] lvl;
      logic [N_CH-1:0] clr;
      logic [N_CH-1:0] eRise, eFall, eTick, eLq, ePend;
   } vec_t;

   function automatic vec_t mkVec(input logic l, input logic c, input logic r, input logic f,
                                  input logic t, input logic q, input logic p);
      vec_t v;
      v.lvl = {3'b000, l}; v.clr = {3'b000, c};
      v.eRise = {3'b000, r}; v.eFall = {3'b000, f}; v.eTick = {3'b000, t};
      v.eLq = {3'b000, q}; v.ePend = {3'b000, p};
      return v;
   endfunction

   task automatic settle();
      repeat (10) applyStimulus('0, 8'h55, '0);
      applyStimulus('0, 8'h55, '1);
      applyStimulus('0, 8'h55, '0);
   endtask

   initial begin
      vec_t vecs[$];
      logic activity;
      int riseCnt, fallCnt, riseCyc, fallCyc, tickCnt, pendSeen;
      logic tickAtRise, tickAtFall;
      logic [N_CH-1:0] lvlR, clrR;
      logic [2*N_CH-1:0] mdR;

      repeat (3) applyStimulus('0, 8'h55, '0);
      checkOutput("reset rise", rise, 0);
      checkOutput("reset fall", fall, 0);
      checkOutput("reset tick", tick, 0);
      checkOutput("reset level_q", level_q, 0);
      checkOutput("reset evt_pend", evt_pend, 0);
      reset = 1'b1;
      modelOn = 1'b1;
      repeat (3) applyStimulus('0, 8'h55, '0);

      // Channel 0, rising mode: acceptance latency, pending flag, clear and set-wins
      for (int n = 0; n < 5; n++) vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(1, 0, 1, 0, 1, 1, 0));
      vecs.push_back(mkVec(1, 0, 0, 0, 0, 1, 1));
      vecs.push_back(mkVec(1, 1, 0, 0, 0, 1, 0));
      for (int n = 0; n < 5; n++) vecs.push_back(mkVec(0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(mkVec(0, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0));
      for (int n = 0; n < 5; n++) vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(1, 0, 1, 0, 1, 1, 0));
      vecs.push_back(mkVec(1, 1, 0, 0, 0, 1, 1));
      vecs.push_back(mkVec(1, 1, 0, 0, 0, 1, 0));
      vecs.push_back(mkVec(1, 0, 0, 0, 0, 1, 0));
      foreach (vecs[n]) begin
         applyStimulus(vecs[n].lvl, 8'h55, vecs[n].clr);
         checkOutput($sformatf("vec%0d rise", n), rise, vecs[n].eRise);
         checkOutput($sformatf("vec%0d fall", n), fall, vecs[n].eFall);
         checkOutput($sformatf("vec%0d tick", n), tick, vecs[n].eTick);
         checkOutput($sformatf("vec%0d level_q", n), level_q, vecs[n].eLq);
         checkOutput($sformatf("vec%0d evt_pend", n), evt_pend, vecs[n].ePend);
      end
      settle();

      // Glitch of 3 cycles on channel 1 must be rejected
      activity = 1'b0;
      repeat (3) begin
         applyStimulus(4'b0010, 8'h55, '0);
         activity |= rise[1] | fall[1] | tick[1] | level_q[1];
      end
      repeat (12) begin
         applyStimulus('0, 8'h55, '0);
         activity |= rise[1] | fall[1] | tick[1] | level_q[1];
      end
      checkOutput("glitch ch1 activity", activity, 0);
      settle();

      // Channel 2 falling-only mode with a 10-cycle pulse
      riseCnt = 0; fallCnt = 0; riseCyc = -1; fallCyc = -1;
      tickAtRise = 1'b0; tickAtFall = 1'b0;
      for (int c = 0; c < 30; c++) begin
         applyStimulus((c < 10) ? 4'b0100 : 4'b0000, 8'h25, '0);
         if (rise[2]) begin riseCnt++; riseCyc = c; tickAtRise |= tick[2]; end
         if (fall[2]) begin fallCnt++; fallCyc = c; tickAtFall = tick[2]; end
      end
      checkOutput("ch2 rise count", riseCnt, 1);
      checkOutput("ch2 rise cycle", riseCyc, 5);
      checkOutput("ch2 tick on rise", tickAtRise, 0);
      checkOutput("ch2 fall count", fallCnt, 1);
      checkOutput("ch2 fall cycle", fallCyc, 15);
      checkOutput("ch2 tick on fall", tickAtFall, 1);
      checkOutput("ch2 evt_pend", evt_pend[2], 1);
      settle();

      // Channel 3 in mode off: pulses still reported, no tick or pending
      riseCnt = 0; fallCnt = 0; tickCnt = 0; pendSeen = 0;
      for (int c = 0; c < 42; c++) begin
         applyStimulus((c < 32 && ((c / 8) % 2 == 0)) ? 4'b1000 : 4'b0000, 8'h15, '0);
         if (rise[3]) riseCnt++;
         if (fall[3]) fallCnt++;
         if (tick[3]) tickCnt++;
         if (evt_pend[3]) pendSeen++;
      end
      checkOutput("ch3 rise count", riseCnt, 2);
      checkOutput("ch3 fall count", fallCnt, 2);
      checkOutput("ch3 tick count", tickCnt, 0);
      checkOutput("ch3 evt_pend seen", pendSeen, 0);
      settle();

      // Reset in the middle of a filter window, level held high through it
      repeat (10) applyStimulus(4'b0010, 8'h55, '0);
      checkOutput("pre-reset level_q", level_q, 4'b0010);
      checkOutput("pre-reset evt_pend", evt_pend, 4'b0010);
      riseCnt = 0; riseCyc = -1;
      for (int c = 0; c < 26; c++) begin
         reset = !(c == 4 || c == 5);
         applyStimulus(4'b0011, 8'h55, '0);
         if (c == 4 || c == 5)
            checkOutput($sformatf("in-reset outputs c%0d", c), {rise, fall, tick, level_q, evt_pend}, 0);
         if (rise[0]) begin riseCnt++; riseCyc = c; end
      end
      reset = 1'b1;
      checkOutput("post-reset ch0 rise count", riseCnt, 1);
      checkOutput("post-reset ch0 rise cycle", riseCyc, 11);
      settle();

      // Randomized traffic against the model
      lvlR = level; mdR = mode;
      for (int c = 0; c < 3000; c++) begin
         for (int ch = 0; ch < N_CH; ch++)
            if ($urandom_range(0, 5) == 0) lvlR[ch] = ~lvlR[ch];
         if ($urandom_range(0, 49) == 0) mdR = (2*N_CH)'($urandom);
         clrR = N_CH'($urandom & $urandom);
         reset = ($urandom_range(0, 299) != 0);
         applyStimulus(lvlR, mdR, clrR);
      end
      reset = 1'b1;
      applyStimulus('0, 8'h55, '0);

      modelOn = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
